// File: rtl/matrix_frame_buffer_pkg.sv
// Shared constants and FSM state for the LED matrix frame buffer and scan driver.
// Package name matrix_pkg; FB_CLEAR_EN enables the post-swap clear walk.
package matrix_pkg;
  localparam int COLS      = 64;
  localparam int ROW_PAIRS = 16;
  localparam int RGB_W     = 3;
  localparam int ADDR_W    = 10;
  localparam int COL_W     = $clog2(COLS);
  localparam int ROW_W     = $clog2(ROW_PAIRS);

  typedef logic [RGB_W-1:0] rgb_t;

  typedef enum logic [1:0] {
    WRITE,
    PEND,
    CLEAR
  } fb_state_e;
endpackage

// File: rtl/matrix_frame_buffer_if.sv
// Producer write port, scan-driver read port and swap status of the frame buffer.
// Optional clear behaviour (FB_CLEAR_EN) does not change this interface.
interface matrix_frame_buffer_if;
  import matrix_pkg::*;

  logic             wr_valid;
  logic             wr_ready;
  logic [COL_W-1:0] wr_x;
  logic [ROW_W:0]   wr_y;
  rgb_t             wr_rgb;
  logic             commit;
  logic             frame_start;
  logic             rd_en;
  logic [ROW_W-1:0] rd_row;
  logic [COL_W-1:0] rd_col;
  rgb_t             rd_rgb0;
  rgb_t             rd_rgb1;
  logic             rd_valid;
  logic             front_sel;
  logic             swap_done;

  modport slave (
    input  wr_valid, wr_x, wr_y, wr_rgb, commit, frame_start,
    input  rd_en, rd_row, rd_col,
    output wr_ready, rd_rgb0, rd_rgb1, rd_valid, front_sel, swap_done
  );

  modport master (
    output wr_valid, wr_x, wr_y, wr_rgb, commit, frame_start,
    output rd_en, rd_row, rd_col,
    input  wr_ready, rd_rgb0, rd_rgb1, rd_valid, front_sel, swap_done
  );
endinterface

// File: rtl/matrix_frame_buffer_bank.sv
// One 1024 x RGB_W simple dual-port RAM bank with synchronous read (fb_bank).
// Contents are never reset; used by matrix_frame_buffer (FB_CLEAR_EN agnostic).
module fb_bank
  import matrix_pkg::*;
(
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  rgb_t              i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output rgb_t              o_rdata
);
  rgb_t r_mem [2**ADDR_W];
  rgb_t r_q;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_q <= r_mem[i_raddr];
  end

  assign o_rdata = r_q;
endmodule

// File: rtl/matrix_frame_buffer.sv
// Double-buffered RGB pixel store feeding the LED matrix scan driver.
// Define FB_CLEAR_EN to zero the new back buffer after every swap.
module matrix_frame_buffer
  import matrix_pkg::*;
(
  input logic                  clk,
  input logic                  rst,
  matrix_frame_buffer_if.slave bus
);
  fb_state_e         r_state;
  fb_state_e         w_next;
  logic              r_front;
  logic              r_wr_ready;
  logic              r_swap_done;
  logic              r_rd_valid;
  logic              r_rd_seen;
  logic              r_rd_buf;
  logic              w_swap;
  logic [1:0]        w_we_half;
  logic [ADDR_W-1:0] w_waddr;
  rgb_t              w_wdata;
  logic [ADDR_W-1:0] w_raddr;
  rgb_t              w_q [2][2];

`ifdef FB_CLEAR_EN
  logic [ADDR_W-1:0] r_clr;
`endif

  assign w_raddr = {bus.rd_row, bus.rd_col};

  always_comb begin
    w_next    = r_state;
    w_swap    = 1'b0;
    w_we_half = 2'b00;
    w_waddr   = {bus.wr_y[ROW_W-1:0], bus.wr_x};
    w_wdata   = bus.wr_rgb;
    unique case (r_state)
      WRITE: begin
        if (bus.wr_valid && r_wr_ready)
          w_we_half[bus.wr_y[ROW_W]] = 1'b1;
        if (bus.commit) w_next = PEND;
      end
      PEND: begin
        if (bus.frame_start) begin
          w_swap = 1'b1;
`ifdef FB_CLEAR_EN
          w_next = CLEAR;
`else
          w_next = WRITE;
`endif
        end
      end
`ifdef FB_CLEAR_EN
      CLEAR: begin
        w_waddr   = r_clr;
        w_wdata   = '0;
        w_we_half = 2'b11;
        if (r_clr == ADDR_W'(2**ADDR_W - 1)) w_next = WRITE;
      end
`endif
      default: w_next = WRITE;
    endcase
  end

  // wr_ready is registered from the next state, never from wr_valid
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= WRITE;
      r_front     <= 1'b0;
      r_wr_ready  <= 1'b1;
      r_swap_done <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_wr_ready  <= (w_next == WRITE);
      r_swap_done <= w_swap;
      if (w_swap) r_front <= ~r_front;
    end
  end

`ifdef FB_CLEAR_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_clr <= '0;
    else if (r_state == CLEAR) r_clr <= r_clr + 1'b1;
  end
`endif

  // read buffer is captured before a same-edge swap lands
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_valid <= 1'b0;
      r_rd_seen  <= 1'b0;
      r_rd_buf   <= 1'b0;
    end else begin
      r_rd_valid <= bus.rd_en;
      if (bus.rd_en) begin
        r_rd_seen <= 1'b1;
        r_rd_buf  <= r_front;
      end
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_buf
    for (genvar h = 0; h < 2; h++) begin : g_half
      fb_bank u_bank (
        .clk     (clk),
        .i_we    (w_we_half[h] && (1'(b) != r_front)),
        .i_waddr (w_waddr),
        .i_wdata (w_wdata),
        .i_re    (bus.rd_en),
        .i_raddr (w_raddr),
        .o_rdata (w_q[b][h])
      );
    end
  end

  assign bus.rd_rgb0   = r_rd_seen ? w_q[r_rd_buf][0] : '0;
  assign bus.rd_rgb1   = r_rd_seen ? w_q[r_rd_buf][1] : '0;
  assign bus.rd_valid  = r_rd_valid;
  assign bus.wr_ready  = r_wr_ready;
  assign bus.front_sel = r_front;
  assign bus.swap_done = r_swap_done;
endmodule

// File: tb/tb_matrix_frame_buffer.sv
// Self-checking bench for matrix_frame_buffer against a pixel-array model.
// Build with or without FB_CLEAR_EN; expectations follow the same macro.
module tb_matrix_frame_buffer;
  import matrix_pkg::*;

`ifdef FB_CLEAR_EN
  localparam int CLR_CYC = 1024;
`else
  localparam int CLR_CYC = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  matrix_frame_buffer_if bus();

  matrix_frame_buffer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  logic [2:0] mem [2][32][64];
  int         m_front;
  int         m_phase;
  int         m_left;
  logic [2:0] e0, e1;
  logic       ev, es;
  int         sd_cnt;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_front = 0;
    m_left  = 0;
    e0 = '0;
    e1 = '0;
    ev = 1'b0;
    es = 1'b0;
  endtask

  task automatic idle();
    bus.wr_valid    = 1'b0;
    bus.wr_x        = '0;
    bus.wr_y        = '0;
    bus.wr_rgb      = '0;
    bus.commit      = 1'b0;
    bus.frame_start = 1'b0;
    bus.rd_en       = 1'b0;
    bus.rd_row      = '0;
    bus.rd_col      = '0;
  endtask

  task automatic check_outs();
    chk("wr_ready", 32'(bus.wr_ready), 32'(m_phase == 0));
    chk("front_sel", 32'(bus.front_sel), 32'(m_front));
    chk("swap_done", 32'(bus.swap_done), 32'(es));
    chk("rd_valid", 32'(bus.rd_valid), 32'(ev));
    if (!$isunknown(e0)) chk("rd_rgb0", 32'(bus.rd_rgb0), 32'(e0));
    if (!$isunknown(e1)) chk("rd_rgb1", 32'(bus.rd_rgb1), 32'(e1));
  endtask

  // model applies the current inputs for the coming edge, then checks
  task automatic tick();
    int idx;
    if (rst) begin
      model_reset();
    end else begin
      ev = bus.rd_en;
      es = 1'b0;
      if (bus.rd_en) begin
        e0 = mem[m_front][{1'b0, bus.rd_row}][bus.rd_col];
        e1 = mem[m_front][{1'b1, bus.rd_row}][bus.rd_col];
      end
      case (m_phase)
        0: begin
          if (bus.wr_valid)
            mem[1-m_front][bus.wr_y][bus.wr_x] = bus.wr_rgb;
          if (bus.commit) m_phase = 1;
        end
        1: if (bus.frame_start) begin
          m_front = 1 - m_front;
          es      = 1'b1;
          m_left  = 1024;
          m_phase = (CLR_CYC != 0) ? 2 : 0;
        end
        default: begin
          idx = 1024 - m_left;
          mem[1-m_front][idx/64][idx%64]      = '0;
          mem[1-m_front][idx/64 + 16][idx%64] = '0;
          m_left--;
          if (m_left == 0) m_phase = 0;
        end
      endcase
    end
    @(posedge clk);
    #1;
    if (bus.swap_done) sd_cnt++;
    check_outs();
  endtask

  task automatic wr(input int x, input int y, input logic [2:0] c);
    bus.wr_valid = 1'b1;
    bus.wr_x     = 6'(x);
    bus.wr_y     = 5'(y);
    bus.wr_rgb   = c;
    tick();
    bus.wr_valid = 1'b0;
  endtask

  task automatic rd(input int row, input int col);
    bus.rd_en  = 1'b1;
    bus.rd_row = 4'(row);
    bus.rd_col = 6'(col);
    tick();
    bus.rd_en = 1'b0;
  endtask

  task automatic pulse_commit();
    bus.commit = 1'b1;
    tick();
    bus.commit = 1'b0;
  endtask

  task automatic pulse_fs();
    bus.frame_start = 1'b1;
    tick();
    bus.frame_start = 1'b0;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!bus.wr_ready && n < 3000) begin
      tick();
      n++;
    end
  endtask

  initial begin
    int n;
    int cnt;
    int row;
    idle();
    model_reset();
    sd_cnt = 0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("rst_ready", 32'(bus.wr_ready), 32'd1);
    chk("rst_front", 32'(bus.front_sel), 32'd0);
    chk("rst_rd0", 32'(bus.rd_rgb0), 32'd0);

    // basic write, commit, swap, read back
    wr(5, 3, 3'b100);
    wr(5, 19, 3'b010);
    pulse_commit();
    sd_cnt = 0;
    pulse_fs();
    chk("swap_front", 32'(bus.front_sel), 32'd1);
    wait_ready(n);
    chk("clear_cycles", 32'(n), 32'(CLR_CYC));
    rd(3, 5);
    chk("basic_rd0", 32'(bus.rd_rgb0), 32'b100);
    chk("basic_rd1", 32'(bus.rd_rgb1), 32'b010);
    chk("basic_vld", 32'(bus.rd_valid), 32'd1);
    tick();
    chk("swap_once", 32'(sd_cnt), 32'd1);

    // commit with a write, then held wr_valid while pending writes nothing
    wr(10, 7, 3'b011);
    bus.commit = 1'b1;
    wr(10, 23, 3'b101);
    bus.commit = 1'b0;
    bus.wr_valid = 1'b1;
    bus.wr_x = 6'd10;
    bus.wr_y = 5'd7;
    bus.wr_rgb = 3'b110;
    for (int i = 0; i < 20; i++) tick();
    chk("pend_ready", 32'(bus.wr_ready), 32'd0);
    chk("pend_front", 32'(bus.front_sel), 32'd1);
    bus.wr_valid = 1'b0;
    pulse_fs();
    wait_ready(n);
    rd(7, 10);
    chk("pend_rd0", 32'(bus.rd_rgb0), 32'b011);
    chk("pend_rd1", 32'(bus.rd_rgb1), 32'b101);

    // commit and frame_start together in WRITE: no swap
    bus.commit = 1'b1;
    bus.frame_start = 1'b1;
    tick();
    idle();
    chk("cf_front", 32'(bus.front_sel), 32'd0);
    chk("cf_ready", 32'(bus.wr_ready), 32'd0);
    pulse_fs();
    chk("cf_swap", 32'(bus.front_sel), 32'd1);
    wait_ready(n);

`ifdef FB_CLEAR_EN
    // back buffer was cleared; swap it to front with no writes
    pulse_commit();
    pulse_fs();
    wait_ready(n);
    for (int i = 0; i < 8; i++) begin
      rd($urandom_range(15), $urandom_range(63));
      chk("zero_rd0", 32'(bus.rd_rgb0), 32'd0);
      chk("zero_rd1", 32'(bus.rd_rgb1), 32'd0);
    end
`endif

    // random full frame with gaps, then sweeps with rd_en held
    for (int y = 0; y < 32; y++) begin
      for (int x = 0; x < 64; x++) begin
        if ($urandom_range(3) == 0) tick();
        wr(x, y, 3'($urandom));
      end
    end
    pulse_commit();
    tick();
    pulse_fs();
    wait_ready(n);
    for (int r = 0; r < 4; r++) begin
      row = $urandom_range(15);
      cnt = 0;
      bus.rd_en  = 1'b1;
      bus.rd_row = 4'(row);
      for (int c = 0; c < 64; c++) begin
        bus.rd_col = 6'(c);
        tick();
        if (bus.rd_valid) cnt++;
      end
      bus.rd_en = 1'b0;
      tick();
      chk("sweep_cnt", 32'(cnt), 32'd64);
    end
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(1) == 1) rd($urandom_range(15), $urandom_range(63));
      else tick();
    end

    // async reset 500 cycles after a swap (mid-clear when enabled)
    pulse_commit();
    pulse_fs();
    for (int i = 0; i < 500; i++) tick();
    rst = 1'b1;
    #1;
    model_reset();
    check_outs();
    tick();
    rst = 1'b0;
    tick();
    chk("post_rst_ready", 32'(bus.wr_ready), 32'd1);
    chk("post_rst_front", 32'(bus.front_sel), 32'd0);
    for (int i = 0; i < 20; i++) rd($urandom_range(15), $urandom_range(63));
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
